// File: rtl/tft_pattern_gen.sv
// rtl/tft_pattern_gen.sv - frame-synchronous RGB565 test-pattern source for the 800x480 TFT path
module tft_pattern_gen #(
  parameter int H_ACTIVE        = 800,
  parameter int V_ACTIVE        = 480,
  parameter int FRAMES_PER_MODE = 60
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [11:0] hcount,
  input  logic [11:0] vcount,
  input  logic        vs,
  input  logic        mode_next,
  input  logic        auto_en,
  output logic [15:0] data_out,
  output logic [2:0]  mode,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [2:0] {
    MODE_SOLID    = 3'd0,
    MODE_VBARS    = 3'd1,
    MODE_HBARS    = 3'd2,
    MODE_GRID     = 3'd3,
    MODE_CHECKER  = 3'd4,
    MODE_GRADIENT = 3'd5,
    MODE_BORDER   = 3'd6
  } mode_t;

  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;

  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE - 1);
  localparam logic [11:0] H_MID    = 12'(H_ACTIVE / 2);
  localparam logic [11:0] V_MID    = 12'(V_ACTIVE / 2);
  localparam logic [11:0] H_BAR    = 12'(H_ACTIVE / 8);
  localparam logic [11:0] V_BAR    = 12'(V_ACTIVE / 8);
  localparam logic [11:0] V_ROW    = 12'(V_ACTIVE / 4);
  localparam logic [7:0]  DWELL_LAST = 8'(FRAMES_PER_MODE - 1);

  // Eight-entry colour palette shared by the indexed patterns.
  function automatic logic [15:0] colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'h0000;
      3'd1:    c = 16'h001F;
      3'd2:    c = 16'hF800;
      3'd3:    c = 16'hF81F;
      3'd4:    c = 16'h07E0;
      3'd5:    c = 16'h07FF;
      3'd6:    c = 16'hFFE0;
      default: c = 16'hFFFF;
    endcase
    return c;
  endfunction

  mode_t       mode_q, mode_nxt;
  logic        vs_d;
  logic        pending, pending_nxt;
  logic [7:0]  dwell, dwell_nxt;
  logic [7:0]  frame_cnt_nxt;
  logic        frame_tick;
  logic        advance;
  logic [15:0] pixel_nxt;

  logic        active;
  logic [2:0]  vbar_idx;
  logic [2:0]  hbar_idx;
  logic [1:0]  grid_row;
  logic        grid_col;
  logic [4:0]  grad_r;
  logic [5:0]  grad_g;
  logic        on_border;

  assign frame_tick = vs_d & ~vs;
  assign mode       = mode_q;

  assign active    = (hcount < 12'(H_ACTIVE)) && (vcount < 12'(V_ACTIVE));
  assign vbar_idx  = 3'(hcount / H_BAR);
  assign hbar_idx  = 3'(vcount / V_BAR);
  assign grid_row  = 2'(vcount / V_ROW);
  assign grid_col  = hcount >= H_MID;
  assign grad_r    = (hcount[11:5] > 7'd31) ? 5'd31 : hcount[9:5];
  assign grad_g    = (vcount[11:3] > 9'd63) ? 6'd63 : vcount[8:3];
  assign on_border = (hcount == 12'd0) || (hcount == H_LAST) ||
                     (vcount == 12'd0) || (vcount == V_LAST) ||
                     (hcount == H_MID) || (vcount == V_MID);

  // Pattern decode for the pixel at the current hcount/vcount; blanking is always black.
  always_comb begin
    pixel_nxt = BLACK;
    if (active) begin
      case (mode_q)
        MODE_SOLID:    pixel_nxt = colour(frame_cnt[5:3]);
        MODE_VBARS:    pixel_nxt = colour(vbar_idx);
        MODE_HBARS:    pixel_nxt = colour(hbar_idx);
        MODE_GRID:     pixel_nxt = colour({grid_row, grid_col});
        MODE_CHECKER:  pixel_nxt = (hcount[4] ^ vcount[4]) ? WHITE : BLACK;
        MODE_GRADIENT: pixel_nxt = {grad_r, grad_g, frame_cnt[4:0]};
        MODE_BORDER:   pixel_nxt = on_border ? WHITE : BLACK;
        default:       pixel_nxt = BLACK;
      endcase
    end
  end

  // Mode sequencing: requests and dwell expiry only take effect on the frame tick.
  always_comb begin
    mode_nxt      = mode_q;
    pending_nxt   = pending | mode_next;
    dwell_nxt     = dwell;
    frame_cnt_nxt = frame_cnt;
    advance       = 1'b0;
    if (frame_tick) begin
      // A pulse landing on the tick itself counts as already pending.
      advance       = pending | mode_next | (auto_en & (dwell == DWELL_LAST));
      frame_cnt_nxt = frame_cnt + 8'd1;
      pending_nxt   = 1'b0;
      if (advance) begin
        dwell_nxt = 8'd0;
        case (mode_q)
          MODE_SOLID:    mode_nxt = MODE_VBARS;
          MODE_VBARS:    mode_nxt = MODE_HBARS;
          MODE_HBARS:    mode_nxt = MODE_GRID;
          MODE_GRID:     mode_nxt = MODE_CHECKER;
          MODE_CHECKER:  mode_nxt = MODE_GRADIENT;
          MODE_GRADIENT: mode_nxt = MODE_BORDER;
          default:       mode_nxt = MODE_SOLID;
        endcase
      end else if (dwell != 8'hFF) begin
        dwell_nxt = dwell + 8'd1;
      end
    end
  end

  // State and output registers; everything returns to its idle value on reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      vs_d      <= 1'b1;
      mode_q    <= MODE_SOLID;
      pending   <= 1'b0;
      dwell     <= 8'd0;
      frame_cnt <= 8'd0;
      data_out  <= BLACK;
    end else begin
      vs_d      <= vs;
      mode_q    <= mode_nxt;
      pending   <= pending_nxt;
      dwell     <= dwell_nxt;
      frame_cnt <= frame_cnt_nxt;
      data_out  <= pixel_nxt;
    end
  end

endmodule
